l_keypad_entry: RTL and testbench

- Input-side counterpart of the lock's seven-segment/LED display path.
- Scans a 4x4 active-low matrix keypad and debounces presses.
- Decodes each press to a 4-bit key value and assembles the 4-digit password word `CODE[15:0]` in the same nibble layout the display consumes.
- Signals the lock FSM with per-key and enter pulses.

---
 rtl/l_keypad_entry_if.sv | 23 ++
 rtl/l_keypad_entry.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_l_keypad_entry.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l_keypad_entry_if.sv
// Keypad matrix and lock-FSM signal bundle for l_keypad_entry.
// The slave side is the scanner itself. The master side is the keypad and
// lock FSM environment that drives COL/CLR and consumes the results.
interface l_keypad_entry_if;
  logic [3:0]  COL;
  logic        CLR;
  logic [3:0]  ROW;
  logic        KEY_VALID;
  logic [3:0]  KEY;
  logic [15:0] CODE;
  logic [2:0]  DIGIT_CNT;
  logic        ENTER;

  modport master (
    output COL, CLR,
    input  ROW, KEY_VALID, KEY, CODE, DIGIT_CNT, ENTER
  );

  modport slave (
    input  COL, CLR,
    output ROW, KEY_VALID, KEY, CODE, DIGIT_CNT, ENTER
  );
endinterface

// File: rtl/l_keypad_entry.sv
// l_keypad_entry: scans a 4x4 active-low keypad, debounces press and release,
// decodes the key and assembles a 4-digit code in display nibble order
// (first digit in CODE[3:0], blank nibbles are 4'hF).
module l_keypad_entry #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic            CLK,
  input  logic            RST,
  l_keypad_entry_if.slave kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  // True when exactly one line of a 4-bit active-low group is low.
  function automatic logic single_low(input logic [3:0] v);
    logic hit;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Position of the single low line in a 4-bit active-low group.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Keypad legend: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
  function automatic logic [3:0] decode_key(input logic [3:0] row, input logic [3:0] col);
    logic [3:0] key;
    case ({low_index(row), low_index(col)})
      4'h0:    key = 4'd1;
      4'h1:    key = 4'd2;
      4'h2:    key = 4'd3;
      4'h3:    key = 4'd10;
      4'h4:    key = 4'd4;
      4'h5:    key = 4'd5;
      4'h6:    key = 4'd6;
      4'h7:    key = 4'd11;
      4'h8:    key = 4'd7;
      4'h9:    key = 4'd8;
      4'hA:    key = 4'd9;
      4'hB:    key = 4'd12;
      4'hC:    key = KEY_STAR;
      4'hD:    key = 4'd0;
      4'hE:    key = KEY_HASH;
      4'hF:    key = KEY_D;
      default: key = 4'd0;
    endcase
    return key;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [3:0]       col_meta_r, col_sync_r;
  logic [DIV_W-1:0] div_r;
  logic [3:0]       row_r, lat_col_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic             sample_s, match_s, released_s, deb_full_s;
  logic             latch_s, deb_clr_s, deb_inc_s, row_adv_s, press_done_s;
  logic [3:0]       key_dec_s;
  logic [15:0]      code_r, code_nxt_s;
  logic [2:0]       dcnt_r, dcnt_nxt_s, dcnt_dec_s;
  logic             enter_nxt_s;
  logic             key_valid_r, enter_r;
  logic [3:0]       key_r;

  assign sample_s   = (div_r == DIV_LAST);
  assign match_s    = (col_sync_r == lat_col_r);
  assign released_s = (col_sync_r == 4'b1111);
  assign deb_full_s = (deb_cnt_r == DEB_LAST);
  assign key_dec_s  = decode_key(row_r, lat_col_r);

  // Two-flop synchronizer for the asynchronous column lines (idle = all high).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col_meta_r <= 4'b1111;
      col_sync_r <= 4'b1111;
    end else begin
      col_meta_r <= kp.COL;
      col_sync_r <= col_meta_r;
    end
  end

  // Free-running row-period divider; its last count marks the sample cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_r <= '0;
    end else if (div_r == DIV_LAST) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_SCAN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; every transition happens on a sample cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SCAN: begin
        if (sample_s && single_low(col_sync_r)) begin
          state_nxt_s = ST_DEBOUNCE;
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_DEBOUNCE: begin
        if (sample_s && !match_s) begin
          state_nxt_s = ST_SCAN;
        end else if (sample_s && deb_full_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_DEBOUNCE;
        end
      end
      ST_HOLD: begin
        if (sample_s && released_s && deb_full_s) begin
          state_nxt_s = ST_SCAN;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_SCAN;
    endcase
  end

  // FSM output decode: latch, debounce-counter, row-rotation and press strobes.
  always_comb begin
    latch_s      = 1'b0;
    deb_clr_s    = 1'b0;
    deb_inc_s    = 1'b0;
    row_adv_s    = 1'b0;
    press_done_s = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (sample_s && single_low(col_sync_r)) begin
          latch_s   = 1'b1;
          deb_clr_s = 1'b1;
        end else if (sample_s) begin
          row_adv_s = 1'b1;
        end else begin
          latch_s = 1'b0;
        end
      end
      ST_DEBOUNCE: begin
        if (sample_s && !match_s) begin
          row_adv_s = 1'b1;
        end else if (sample_s && deb_full_s) begin
          press_done_s = 1'b1;
          deb_clr_s    = 1'b1;
        end else if (sample_s) begin
          deb_inc_s = 1'b1;
        end else begin
          deb_inc_s = 1'b0;
        end
      end
      ST_HOLD: begin
        if (sample_s && !released_s) begin
          deb_clr_s = 1'b1;
        end else if (sample_s && deb_full_s) begin
          row_adv_s = 1'b1;
          deb_clr_s = 1'b1;
        end else if (sample_s) begin
          deb_inc_s = 1'b1;
        end else begin
          deb_inc_s = 1'b0;
        end
      end
      default: begin
        row_adv_s = 1'b0;
      end
    endcase
  end

  // Row drive, latched column pattern and debounce counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_r     <= 4'b1110;
      lat_col_r <= 4'b1111;
      deb_cnt_r <= '0;
    end else begin
      if (row_adv_s) begin
        row_r <= {row_r[2:0], row_r[3]};
      end else begin
        row_r <= row_r;
      end
      if (latch_s) begin
        lat_col_r <= col_sync_r;
      end else begin
        lat_col_r <= lat_col_r;
      end
      if (deb_clr_s) begin
        deb_cnt_r <= '0;
      end else if (deb_inc_s) begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end else begin
        deb_cnt_r <= deb_cnt_r;
      end
    end
  end

  // Entry-buffer update; CLR overrides any key action and blocks ENTER.
  always_comb begin
    code_nxt_s  = code_r;
    dcnt_nxt_s  = dcnt_r;
    enter_nxt_s = 1'b0;
    dcnt_dec_s  = dcnt_r - 3'd1;
    if (kp.CLR) begin
      code_nxt_s = 16'hFFFF;
      dcnt_nxt_s = 3'd0;
    end else if (press_done_s) begin
      case (key_dec_s)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
          if (dcnt_r < 3'd4) begin
            code_nxt_s[{dcnt_r[1:0], 2'b00} +: 4] = key_dec_s;
            dcnt_nxt_s = dcnt_r + 3'd1;
          end else begin
            dcnt_nxt_s = dcnt_r;
          end
        end
        KEY_STAR: begin
          if (dcnt_r != 3'd0) begin
            code_nxt_s[{dcnt_dec_s[1:0], 2'b00} +: 4] = 4'hF;
            dcnt_nxt_s = dcnt_dec_s;
          end else begin
            dcnt_nxt_s = dcnt_r;
          end
        end
        KEY_D: begin
          code_nxt_s = 16'hFFFF;
          dcnt_nxt_s = 3'd0;
        end
        KEY_HASH: begin
          if (dcnt_r == 3'd4) begin
            enter_nxt_s = 1'b1;
          end else begin
            enter_nxt_s = 1'b0;
          end
        end
        default: begin
          enter_nxt_s = 1'b0;
        end
      endcase
    end else begin
      enter_nxt_s = 1'b0;
    end
  end

  // Registered outputs: key report, entry buffer and enter pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_valid_r <= 1'b0;
      key_r       <= 4'd0;
      code_r      <= 16'hFFFF;
      dcnt_r      <= 3'd0;
      enter_r     <= 1'b0;
    end else begin
      key_valid_r <= press_done_s;
      if (press_done_s) begin
        key_r <= key_dec_s;
      end else begin
        key_r <= key_r;
      end
      code_r  <= code_nxt_s;
      dcnt_r  <= dcnt_nxt_s;
      enter_r <= enter_nxt_s;
    end
  end

  assign kp.ROW       = row_r;
  assign kp.KEY_VALID = key_valid_r;
  assign kp.KEY       = key_r;
  assign kp.CODE      = code_r;
  assign kp.DIGIT_CNT = dcnt_r;
  assign kp.ENTER     = enter_r;

endmodule

// File: tb/tb_l_keypad_entry.sv
// Testbench for l_keypad_entry with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A keypad model drives COL from ROW and the set of pressed keys. A
// per-row-period reference model predicts all outputs.
module tb_l_keypad_entry;
  localparam int DIV = 4;
  localparam int DEB = 3;

  logic CLK = 1'b0;
  logic RST;
  l_keypad_entry_if ifc ();

  l_keypad_entry #(.SCAN_DIV(DIV), .DEBOUNCE_CNT(DEB)) dut (
    .CLK(CLK),
    .RST(RST),
    .kp (ifc)
  );

  always #5 CLK = ~CLK;

  int kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  bit pressed [4][4];
  logic [3:0] col_s;

  // Passive keypad: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    col_s = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !ifc.ROW[r]) col_s[c] = 1'b0;
  end
  assign ifc.COL = col_s;

  int total = 0;
  int bad = 0;
  int kv_seen = 0;
  int en_seen = 0;

  // Count output pulses independently of the model.
  always @(negedge CLK) begin
    if (ifc.KEY_VALID === 1'b1) kv_seen++;
    if (ifc.ENTER === 1'b1) en_seen++;
  end

  // Reference model state (scan mode 0, debounce 1, hold 2).
  int m_row, m_mode, m_cnt, m_key;
  logic [3:0] m_lat;
  int q[$];
  bit exp_kv, exp_enter;
  bit clr_on_event = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sampled(input int row);
    logic [3:0] s;
    s = 4'hF;
    for (int c = 0; c < 4; c++) if (pressed[row][c]) s[c] = 1'b0;
    return s;
  endfunction

  function automatic logic [15:0] exp_code();
    logic [15:0] v;
    v = 16'hFFFF;
    for (int i = 0; i < q.size(); i++) v[i*4 +: 4] = 4'(q[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_row = 0; m_mode = 0; m_cnt = 0; m_key = 0; m_lat = 4'hF;
    q.delete();
  endtask

  task automatic model_sample(output bit ev, output int kv);
    logic [3:0] s;
    int ci;
    s = sampled(m_row);
    ev = 1'b0; kv = 0; ci = 0;
    if (m_mode == 0) begin
      if ($countones(~s) == 1) begin m_lat = s; m_cnt = 0; m_mode = 1; end
      else m_row = (m_row + 1) % 4;
    end else if (m_mode == 1) begin
      if (s == m_lat) begin
        m_cnt++;
        if (m_cnt == DEB) begin
          for (int c = 0; c < 4; c++) if (!m_lat[c]) ci = c;
          ev = 1'b1; kv = kmap[m_row][ci]; m_mode = 2; m_cnt = 0;
        end
      end else begin
        m_mode = 0; m_row = (m_row + 1) % 4;
      end
    end else begin
      if (s == 4'hF) begin
        m_cnt++;
        if (m_cnt == DEB) begin m_mode = 0; m_row = (m_row + 1) % 4; end
      end else m_cnt = 0;
    end
  endtask

  task automatic model_buffer(input bit ev, input int kv, input bit clr);
    exp_kv = ev;
    exp_enter = 1'b0;
    if (ev) m_key = kv;
    if (clr) q.delete();
    else if (ev) begin
      if (kv <= 9) begin if (q.size() < 4) q.push_back(kv); end
      else if (kv == 14) begin if (q.size() > 0) void'(q.pop_back()); end
      else if (kv == 13) q.delete();
      else if (kv == 15) exp_enter = (q.size() == 4);
    end
  endtask

  // One row period: starts 1 time unit after a sample edge, ends likewise.
  task automatic period(input bit clr_req);
    bit ev, clr;
    int kv;
    logic [3:0] er;
    model_sample(ev, kv);
    clr = clr_req || (clr_on_event && ev);
    for (int e = 0; e < DIV; e++) begin
      if (e == DIV - 1) ifc.CLR = clr;
      @(posedge CLK); #1;
      if (e == 0) begin
        chk("kv_one_cycle", 32'(ifc.KEY_VALID), 32'(0));
        chk("enter_one_cycle", 32'(ifc.ENTER), 32'(0));
      end
    end
    ifc.CLR = 1'b0;
    model_buffer(ev, kv, clr);
    er = 4'hF; er[m_row] = 1'b0;
    chk("row", 32'(ifc.ROW), 32'(er));
    chk("key_valid", 32'(ifc.KEY_VALID), 32'(exp_kv));
    chk("key", 32'(ifc.KEY), 32'(m_key));
    chk("code", 32'(ifc.CODE), 32'(exp_code()));
    chk("digit_cnt", 32'(ifc.DIGIT_CNT), 32'(q.size()));
    chk("enter", 32'(ifc.ENTER), 32'(exp_enter));
  endtask

  task automatic set_key(input int v, input bit on);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (kmap[r][c] == v) pressed[r][c] = on;
  endtask

  task automatic tap(input int v, input int on_p, input int off_p, input bit rnd_clr);
    set_key(v, 1'b1);
    for (int i = 0; i < on_p; i++) period(rnd_clr && ($urandom_range(0, 7) == 0));
    set_key(v, 1'b0);
    for (int i = 0; i < off_p; i++) period(rnd_clr && ($urandom_range(0, 7) == 0));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_row"}, 32'(ifc.ROW), 32'(4'b1110));
    chk({tag, "_kv"}, 32'(ifc.KEY_VALID), 32'(0));
    chk({tag, "_key"}, 32'(ifc.KEY), 32'(0));
    chk({tag, "_code"}, 32'(ifc.CODE), 32'(16'hFFFF));
    chk({tag, "_cnt"}, 32'(ifc.DIGIT_CNT), 32'(0));
    chk({tag, "_enter"}, 32'(ifc.ENTER), 32'(0));
  endtask

  int k0, e0;

  initial begin
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
    ifc.CLR = 1'b0;
    RST = 1'b1;
    #2;
    reset_checks("rst");
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();

    // Bounce on key 5: 2 low, 1 high, 2 low, then release.
    k0 = kv_seen;
    set_key(5, 1'b1); period(0); period(0);
    set_key(5, 1'b0); period(0);
    set_key(5, 1'b1); period(0); period(0);
    set_key(5, 1'b0); for (int i = 0; i < 4; i++) period(0);
    chk("bounce_no_kv", 32'(kv_seen - k0), 32'(0));
    chk("bounce_code", 32'(ifc.CODE), 32'(16'hFFFF));

    // Key 5 held for 20 row periods, then released.
    k0 = kv_seen;
    set_key(5, 1'b1);
    for (int i = 0; i < 20; i++) period(0);
    chk("hold_row_frozen", 32'(ifc.ROW), 32'(4'b1101));
    set_key(5, 1'b0);
    for (int i = 0; i < 6; i++) period(0);
    chk("key5_one_kv", 32'(kv_seen - k0), 32'(1));
    chk("key5_code", 32'(ifc.CODE), 32'(16'hFFF5));
    chk("key5_cnt", 32'(ifc.DIGIT_CNT), 32'(1));

    // 1,2,3,4,5 then #: fifth digit dropped, one ENTER.
    tap(13, 9, 4, 0);
    e0 = en_seen;
    for (int d = 1; d <= 5; d++) tap(d, 9, 4, 0);
    tap(15, 9, 4, 0);
    chk("full_code", 32'(ifc.CODE), 32'(16'h4321));
    chk("full_cnt", 32'(ifc.DIGIT_CNT), 32'(4));
    chk("full_enter", 32'(en_seen - e0), 32'(1));

    // 7,8,*,9 then # without ENTER.
    tap(13, 9, 4, 0);
    tap(7, 9, 4, 0); tap(8, 9, 4, 0); tap(14, 9, 4, 0);
    chk("bksp_code", 32'(ifc.CODE), 32'(16'hFFF7));
    tap(9, 9, 4, 0);
    chk("bksp_code2", 32'(ifc.CODE), 32'(16'hFF97));
    chk("bksp_cnt", 32'(ifc.DIGIT_CNT), 32'(2));
    e0 = en_seen;
    tap(15, 9, 4, 0);
    chk("short_no_enter", 32'(en_seen - e0), 32'(0));

    // Two columns low in one row: ignored.
    k0 = kv_seen;
    set_key(1, 1'b1); set_key(2, 1'b1);
    for (int i = 0; i < 10; i++) period(0);
    set_key(1, 1'b0); set_key(2, 1'b0);
    period(0);
    chk("twocol_no_kv", 32'(kv_seen - k0), 32'(0));

    // CLR on the same edge as a completing #.
    tap(13, 9, 4, 0);
    for (int d = 1; d <= 4; d++) tap(d, 9, 4, 0);
    e0 = en_seen; k0 = kv_seen;
    clr_on_event = 1'b1;
    tap(15, 9, 4, 0);
    clr_on_event = 1'b0;
    chk("clr_kv", 32'(kv_seen - k0), 32'(1));
    chk("clr_key", 32'(ifc.KEY), 32'(15));
    chk("clr_code", 32'(ifc.CODE), 32'(16'hFFFF));
    chk("clr_cnt", 32'(ifc.DIGIT_CNT), 32'(0));
    chk("clr_no_enter", 32'(en_seen - e0), 32'(0));

    // Reset during HOLD of key 0, key still held afterwards.
    set_key(0, 1'b1);
    for (int i = 0; i < 9; i++) period(0);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    reset_checks("midrst");
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    k0 = kv_seen;
    for (int i = 0; i < 8; i++) period(0);
    chk("rehold_kv", 32'(kv_seen - k0), 32'(1));
    chk("rehold_key", 32'(ifc.KEY), 32'(0));
    chk("rehold_code", 32'(ifc.CODE), 32'(16'hFFF0));
    set_key(0, 1'b0);
    for (int i = 0; i < 4; i++) period(0);

    // Randomized presses, durations and CLR pulses against the model.
    for (int n = 0; n < 40; n++)
      tap($urandom_range(0, 15), $urandom_range(1, 9), $urandom_range(0, 5), 1'b1);
    for (int i = 0; i < 4; i++) period(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
